// File: rtl/sdram_port_arbiter.sv
// Two-port round-robin arbiter/sequencer in front of a single-port SDRAM controller.
// Latches the winning command, issues a one-cycle start, waits for completion or watchdog abort.
module sdram_port_arbiter #(
    parameter int ROW_W   = 12,
    parameter int COL_W   = 8,
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [ROW_W-1:0]  p0_row,
    input  logic [COL_W-1:0]  p0_col,
    input  logic [DATA_W-1:0] p0_wdata,
    output logic              p0_done,
    output logic              p0_err,
    output logic [DATA_W-1:0] p0_rdata,
    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [ROW_W-1:0]  p1_row,
    input  logic [COL_W-1:0]  p1_col,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              p1_done,
    output logic              p1_err,
    output logic [DATA_W-1:0] p1_rdata,
    output logic              mem_rd_start,
    output logic              mem_wr_start,
    output logic [ROW_W-1:0]  mem_row,
    output logic [COL_W-1:0]  mem_col,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_rd_valid,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_wr_valid,
    output logic              busy,
    output logic              grant
);

    localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DONE
    } state_e;

    state_e            state_q, state_d;
    logic              last_grant_q, last_grant_d;
    logic              grant_q, grant_d;
    logic              we_q, we_d;
    logic              err_q, err_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [ROW_W-1:0]  row_q, row_d;
    logic [COL_W-1:0]  col_q, col_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              win;
    logic              op_valid;

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        grant_d      = grant_q;
        we_d         = we_q;
        err_d        = err_q;
        cnt_d        = cnt_q;
        rdata_d      = rdata_q;
        row_d        = row_q;
        col_d        = col_q;
        wdata_d      = wdata_q;
        // On a tie the port that did not win last time goes next.
        win          = (p0_req && p1_req) ? ~last_grant_q : ~p0_req;
        op_valid     = we_q ? mem_wr_valid : mem_rd_valid;

        case (state_q)
            S_IDLE: begin
                if (p0_req || p1_req) begin
                    grant_d = win;
                    we_d    = win ? p1_we    : p0_we;
                    row_d   = win ? p1_row   : p0_row;
                    col_d   = win ? p1_col   : p0_col;
                    wdata_d = win ? p1_wdata : p0_wdata;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (op_valid) begin
                    err_d        = 1'b0;
                    rdata_d      = we_q ? '0 : mem_rdata;
                    last_grant_d = grant_q;
                    state_d      = S_DONE;
                end else if (cnt_q == CNT_W'(TIMEOUT)) begin
                    err_d        = 1'b1;
                    rdata_d      = '0;
                    last_grant_d = grant_q;
                    state_d      = S_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            last_grant_q <= 1'b1;
            grant_q      <= 1'b0;
            we_q         <= 1'b0;
            err_q        <= 1'b0;
            cnt_q        <= '0;
            rdata_q      <= '0;
            row_q        <= '0;
            col_q        <= '0;
            wdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            grant_q      <= grant_d;
            we_q         <= we_d;
            err_q        <= err_d;
            cnt_q        <= cnt_d;
            rdata_q      <= rdata_d;
            row_q        <= row_d;
            col_q        <= col_d;
            wdata_q      <= wdata_d;
        end
    end

    assign busy         = (state_q != S_IDLE);
    assign grant        = grant_q;
    assign mem_rd_start = (state_q == S_ISSUE) && !we_q;
    assign mem_wr_start = (state_q == S_ISSUE) &&  we_q;
    assign mem_row      = row_q;
    assign mem_col      = col_q;
    assign mem_wdata    = wdata_q;

    assign p0_done  = (state_q == S_DONE) && !grant_q;
    assign p1_done  = (state_q == S_DONE) &&  grant_q;
    assign p0_err   = p0_done && err_q;
    assign p1_err   = p1_done && err_q;
    assign p0_rdata = p0_done ? rdata_q : '0;
    assign p1_rdata = p1_done ? rdata_q : '0;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Directed plus randomized bench for sdram_port_arbiter against a transaction-level reference model.
module tb_sdram_port_arbiter;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        p0_req = 1'b0, p0_we = 1'b0;
    logic [11:0] p0_row = '0;
    logic [7:0]  p0_col = '0;
    logic [15:0] p0_wdata = '0;
    logic        p0_done, p0_err;
    logic [15:0] p0_rdata;
    logic        p1_req = 1'b0, p1_we = 1'b0;
    logic [11:0] p1_row = '0;
    logic [7:0]  p1_col = '0;
    logic [15:0] p1_wdata = '0;
    logic        p1_done, p1_err;
    logic [15:0] p1_rdata;
    logic        mem_rd_start, mem_wr_start;
    logic [11:0] mem_row;
    logic [7:0]  mem_col;
    logic [15:0] mem_wdata;
    logic        mem_rd_valid = 1'b0, mem_wr_valid = 1'b0;
    logic [15:0] mem_rdata = '0;
    logic        busy, grant;

    int n_cmp = 0;
    int n_fail = 0;
    logic mlast = 1'b1;

    sdram_port_arbiter #(
        .ROW_W(12), .COL_W(8), .DATA_W(16), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .p0_req(p0_req), .p0_we(p0_we), .p0_row(p0_row), .p0_col(p0_col), .p0_wdata(p0_wdata),
        .p0_done(p0_done), .p0_err(p0_err), .p0_rdata(p0_rdata),
        .p1_req(p1_req), .p1_we(p1_we), .p1_row(p1_row), .p1_col(p1_col), .p1_wdata(p1_wdata),
        .p1_done(p1_done), .p1_err(p1_err), .p1_rdata(p1_rdata),
        .mem_rd_start(mem_rd_start), .mem_wr_start(mem_wr_start),
        .mem_row(mem_row), .mem_col(mem_col), .mem_wdata(mem_wdata),
        .mem_rd_valid(mem_rd_valid), .mem_rdata(mem_rdata), .mem_wr_valid(mem_wr_valid),
        .busy(busy), .grant(grant)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, compared=%0d", n_cmp);
        $fatal(1, "time limit");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs();
        check("rst_busy", 32'(busy), 0);
        check("rst_starts", {30'd0, mem_rd_start, mem_wr_start}, 0);
        check("rst_done", {30'd0, p0_done, p1_done}, 0);
        check("rst_err", {30'd0, p0_err, p1_err}, 0);
        check("rst_rdata", {p0_rdata, p1_rdata}, 0);
        check("rst_mem", {4'd0, mem_row, mem_col, 8'd0}, 0);
        check("rst_wdata", 32'(mem_wdata), 0);
        check("rst_grant", 32'(grant), 0);
    endtask

    // One access from IDLE: d = WAIT cycle index at which the right-type valid is given.
    task automatic run_txn(input bit give_valid, input int d, input int wrong_at,
                           input logic [15:0] rd_val, input bit keep);
        logic        w, ewe, eerr;
        logic [11:0] erow;
        logic [7:0]  ecol;
        logic [15:0] ewd, erd;
        int          nwait;
        w     = (p0_req && p1_req) ? ~mlast : (p0_req ? 1'b0 : 1'b1);
        ewe   = w ? p1_we : p0_we;
        erow  = w ? p1_row : p0_row;
        ecol  = w ? p1_col : p0_col;
        ewd   = w ? p1_wdata : p0_wdata;
        eerr  = !(give_valid && d <= TO);
        nwait = eerr ? TO + 1 : d + 1;
        erd   = (!eerr && !ewe) ? rd_val : 16'h0;

        @(posedge clk); @(negedge clk);
        check("issue_busy", 32'(busy), 1);
        check("issue_grant", 32'(grant), 32'(w));
        check("issue_rd_start", 32'(mem_rd_start), 32'(!ewe));
        check("issue_wr_start", 32'(mem_wr_start), 32'(ewe));
        check("issue_row", 32'(mem_row), 32'(erow));
        check("issue_col", 32'(mem_col), 32'(ecol));
        check("issue_wdata", 32'(mem_wdata), 32'(ewd));
        @(posedge clk);
        for (int i = 0; i < nwait; i++) begin
            @(negedge clk);
            check("wait_starts", {30'd0, mem_rd_start, mem_wr_start}, 0);
            check("wait_done", {30'd0, p0_done, p1_done}, 0);
            mem_rd_valid = give_valid && (i == d) && !ewe;
            mem_wr_valid = give_valid && (i == d) && ewe;
            if (i == wrong_at) begin
                if (ewe) mem_rd_valid = 1'b1;
                else     mem_wr_valid = 1'b1;
            end
            mem_rdata = (give_valid && i == d && !ewe) ? rd_val : 16'($urandom);
            @(posedge clk);
        end
        @(negedge clk);
        mem_rd_valid = 1'b0;
        mem_wr_valid = 1'b0;
        check("done_win", 32'(w ? p1_done : p0_done), 1);
        check("done_other", 32'(w ? p0_done : p1_done), 0);
        check("done_err", 32'(w ? p1_err : p0_err), 32'(eerr));
        check("done_rdata", 32'(w ? p1_rdata : p0_rdata), 32'(erd));
        check("done_mem_hold", {mem_row, mem_col, 12'd0}, {erow, ecol, 12'd0});
        check("done_wdata_hold", 32'(mem_wdata), 32'(ewd));
        mlast = w;
        if (!keep) begin
            if (w) p1_req = 1'b0;
            else   p0_req = 1'b0;
        end
        @(posedge clk); @(negedge clk);
        check("idle_busy", 32'(busy), 0);
        check("idle_done", {30'd0, p0_done, p1_done}, 0);
    endtask

    initial begin
        #1;
        check_reset_outputs();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // single read on port 0
        p0_req = 1'b1; p0_we = 1'b0; p0_row = 12'h123; p0_col = 8'h45; p0_wdata = 16'h1111;
        run_txn(1'b1, 2, -1, 16'hBEEF, 1'b0);

        // single write on port 1
        p1_req = 1'b1; p1_we = 1'b1; p1_row = 12'h0AB; p1_col = 8'h0C; p1_wdata = 16'hA5A5;
        run_txn(1'b1, 1, -1, 16'h0000, 1'b0);

        // tie held for four accesses
        p0_req = 1'b1; p0_we = 1'b0; p0_row = 12'h010; p0_col = 8'h01;
        p1_req = 1'b1; p1_we = 1'b1; p1_row = 12'h020; p1_col = 8'h02; p1_wdata = 16'h5A5A;
        for (int k = 0; k < 4; k++) run_txn(1'b1, k % 3, -1, 16'(16'h1000 + k), 1'b1);
        p0_req = 1'b0; p1_req = 1'b0;

        // timeout, then a normal access
        p0_req = 1'b1; p0_we = 1'b0; p0_row = 12'h3FF; p0_col = 8'hFF;
        run_txn(1'b0, 0, -1, 16'h0, 1'b0);
        p0_req = 1'b1; p0_we = 1'b1; p0_wdata = 16'hC0DE;
        run_txn(1'b1, 0, -1, 16'h0, 1'b0);

        // wrong-type valid ignored, right-type valid on the timeout cycle wins
        p0_req = 1'b1; p0_we = 1'b0; p0_row = 12'h777; p0_col = 8'h77;
        run_txn(1'b1, TO, 1, 16'h4321, 1'b0);

        // reset asserted during WAIT
        p0_req = 1'b1; p0_we = 1'b0; p0_row = 12'h555; p0_col = 8'h55;
        @(posedge clk); @(posedge clk); @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_reset_outputs();
        p0_req = 1'b0;
        @(negedge clk);
        check("rst_hold_busy", 32'(busy), 0);
        rst_n = 1'b1;
        mlast = 1'b1;
        p0_req = 1'b1; p0_we = 1'b1; p0_row = 12'h101; p0_col = 8'h10; p0_wdata = 16'h0F0F;
        p1_req = 1'b1; p1_we = 1'b0; p1_row = 12'h202; p1_col = 8'h20;
        run_txn(1'b1, 0, -1, 16'h0, 1'b0);
        run_txn(1'b1, 1, -1, 16'h9876, 1'b0);

        // randomized traffic
        for (int t = 0; t < 40; t++) begin
            if (!p0_req && ($urandom % 2 == 0)) begin
                p0_req = 1'b1; p0_we = 1'($urandom); p0_row = 12'($urandom);
                p0_col = 8'($urandom); p0_wdata = 16'($urandom);
            end
            if (!p1_req && ($urandom % 2 == 0)) begin
                p1_req = 1'b1; p1_we = 1'($urandom); p1_row = 12'($urandom);
                p1_col = 8'($urandom); p1_wdata = 16'($urandom);
            end
            if (!p0_req && !p1_req) begin
                p0_req = 1'b1; p0_we = 1'($urandom); p0_row = 12'($urandom);
                p0_col = 8'($urandom); p0_wdata = 16'($urandom);
            end
            run_txn(($urandom % 4) != 0, int'($urandom_range(0, TO + 1)),
                    int'($urandom_range(0, 6)), 16'($urandom), 1'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/sdram_port_arbiter.md
# sdram_port_arbiter

Two-port round-robin arbiter and sequencer in front of the single-port SDRAM controller in the TinyTapeout top. It accepts read/write requests from two requesters, grants one at a time, and drives the controller's start/address/data inputs. It then waits for the controller's read- or write-valid completion and returns read data and a done pulse to the granted requester. A watchdog aborts any access the controller fails to complete.

## Interface
- ROW_W, 12, row address width
- COL_W, 8, column address width
- DATA_W, 16, data width
- TIMEOUT, 255, maximum WAIT cycles before abort (≥1)

- clk  in  1  single clock, all logic rising-edge
- rst_n  in  1  asynchronous, active-low reset
- pN_req  in  1  (N=0,1) level request; held with command fields until pN_done
- pN_we  in  1  1=write, 0=read
- pN_row  in  ROW_W  row address
- pN_col  in  COL_W  column address
- pN_wdata  in  DATA_W  write data
- pN_done  out  1  one-cycle completion pulse
- pN_err  out  1  valid with pN_done; 1=timeout abort
- pN_rdata  out  DATA_W  read data, valid with pN_done
- mem_rd_start  out  1  one-cycle read start to controller
- mem_wr_start  out  1  one-cycle write start to controller
- mem_row  out  ROW_W  registered row address
- mem_col  out  COL_W  registered column address
- mem_wdata  out  DATA_W  registered write data
- mem_rd_valid  in  1  controller read complete; mem_rdata valid this cycle
- mem_rdata  in  DATA_W  controller read data
- mem_wr_valid  in  1  controller write complete
- busy  out  1  high whenever state ≠ IDLE
- grant  out  1  index of port owning the controller (meaningful while busy)

## Operation
- States: IDLE → ISSUE → WAIT → DONE → IDLE.
- IDLE: if any req, choose winner; latch we/row/col/wdata of winner into mem_* regs, set grant; → ISSUE.
- Arbitration: single req wins outright. Both req: port ≠ last_grant wins. last_grant updates at DONE entry.
- ISSUE: exactly one of mem_rd_start/mem_wr_start high (per latched we); clear watchdog counter; → WAIT.
- WAIT: read op completes on mem_rd_valid, capturing mem_rdata. Write op completes on mem_wr_valid, with rdata = 0. Valid of the wrong type is ignored. Completion → DONE with err=0. Otherwise the counter increments; at counter == TIMEOUT → DONE with err=1, rdata=0.
- Valid and timeout in the same cycle: valid wins, err=0.
- DONE: p[grant]_done=1 for one cycle, with err/rdata; other port's done stays 0. → IDLE.
- A req still high in the IDLE cycle after DONE is a new request; requesters drop req in the DONE cycle.
- mem_row/col/wdata stay stable from ISSUE through DONE; they hold their values in IDLE.
- Watchdog counter width: clog2(TIMEOUT+1); it never wraps.

## Timing
- Reset (async assert): state IDLE, last_grant=1 (so port 0 wins first tie), grant=0, counter=0. All outputs 0: starts, done, err, rdata, mem_row/col/wdata, busy.
- Reset release is synchronous to clk; the first arbitration occurs on the first edge with rst_n high.
- Request seen at edge k (IDLE) → start pulse during cycle k+1 → WAIT from k+2.
- Valid sampled at WAIT edge j → done pulse during cycle j+1 → IDLE at j+2.
- Minimum turnaround: 4 cycles per access (IDLE, ISSUE, WAIT with valid, DONE).
- Timeout: done/err after TIMEOUT+1 WAIT cycles.
- Reset mid-access: immediate abort, no done pulse, outputs to reset values.
- Valid arriving during ISSUE is ignored; the controller must not respond before WAIT.

## Test plan
- Single read: p0_req, we=0, row=0x123, col=0x45; controller returns valid + 0xBEEF 3 cycles after start → exactly one rd_start pulse, mem_row=0x123, p0_done with rdata=0xBEEF, err=0, p1_done never high.
- Single write: p1_req, we=1, wdata=0xA5A5 → mem_wr_start once, mem_wdata=0xA5A5, p1_done with rdata=0, err=0.
- Tie/fairness: both req held continuously for 4 accesses → grants 0,1,0,1 (after reset), each with exactly one done.
- Timeout: TIMEOUT=4, no valid → p0_done with err=1 exactly 5 WAIT cycles after ISSUE; next request then proceeds normally.
- Wrong-type and coincident valid: a read access sees mem_wr_valid (ignored), then mem_rd_valid on the timeout cycle → err=0, data captured.
- Reset in WAIT: rst_n low mid-access → busy, starts and done go 0 immediately, no done pulse; after release, p0 wins the first tie.
